// File: rtl/fact_arb.sv
// rtl/fact_arb.sv - round-robin scheduler sharing one factorial engine between NREQ requesters
// Grants one requester at a time, drives the engine, returns result/error with a watchdog abort.
module fact_arb #(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_n,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      res,
  output logic                  err,
  output logic                  busy,
  output logic                  f_go,
  output logic [WIDTH-1:0]      f_n,
  input  logic                  f_done,
  input  logic                  f_err,
  input  logic [WIDTH-1:0]      f_nf
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W  = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  localparam bit WD_EN = (TO_CYCLES != 0);
  localparam logic [WD_W-1:0]  WD_LAST = WD_EN ? WD_W'(TO_CYCLES - 1) : '0;
  localparam logic [IDX_W:0]   NREQ_V  = (IDX_W + 1)'(NREQ);
  localparam logic [NREQ-1:0]  ONE     = NREQ'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [WD_W-1:0]  wd;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] pick;
  logic             found;

  // Scan ptr+1, ptr+2, ... so the last served requester is considered last.
  always_comb begin
    cand  = '0;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (cand >= NREQ_V) cand = cand - NREQ_V;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= IDX_W'(NREQ - 1);
      owner <= '0;
      wd    <= '0;
      ack   <= '0;
      done  <= '0;
      res   <= '0;
      err   <= 1'b0;
      busy  <= 1'b0;
      f_go  <= 1'b0;
      f_n   <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            f_n   <= req_n[pick*WIDTH +: WIDTH];
            owner <= pick;
            ptr   <= pick;
            ack   <= ONE << pick;
            f_go  <= 1'b1;
            busy  <= 1'b1;
            wd    <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // A completion on the same edge as the timeout wins.
          if (f_done) begin
            res   <= f_nf;
            err   <= f_err;
            done  <= ONE << owner;
            f_go  <= 1'b0;
            state <= DRAIN;
          end else if (WD_EN && wd == WD_LAST) begin
            res   <= '0;
            err   <= 1'b1;
            done  <= ONE << owner;
            f_go  <= 1'b0;
            state <= DRAIN;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DRAIN: begin
          if (!f_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          f_go  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fact_arb.sv
// tb/tb_fact_arb.sv - scoreboard bench for fact_arb with an engine stub and random requesters
module tb_fact_arb;
  localparam int W = 32, N = 4, TO = 16, HANG = 100;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_n;
  logic [N-1:0]   ack, done;
  logic [W-1:0]   res, f_n, f_nf;
  logic           err, busy, f_go, f_done, f_err;

  fact_arb #(.WIDTH(W), .NREQ(N), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_n(req_n), .ack(ack), .done(done),
    .res(res), .err(err), .busy(busy), .f_go(f_go), .f_n(f_n),
    .f_done(f_done), .f_err(f_err), .f_nf(f_nf)
  );

  always #5 clk = ~clk;

  typedef struct {logic [W-1:0] res; logic err; bit hang;} exp_t;

  exp_t         q[N][$];
  logic [W-1:0] op[N];
  int           fixed_tbl[N];
  int           n_checks = 0, n_pass = 0;
  int           cycle = 0;
  int           active = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [63:0] fact64(input int n);
    logic [63:0] r = 64'd1;
    for (int i = 2; i <= n; i++) r = r * 64'(i);
    return r;
  endfunction

  // Round robin: first requesting index after the most recently served one.
  function automatic int next_owner(input logic [N-1:0] r, input int last);
    for (int j = 1; j <= N; j++)
      if (r[(last + j) % N]) return (last + j) % N;
    return -1;
  endfunction

  // Engine stub: answers after a random delay, never answers for HANG.
  initial begin
    int cnt, hold_cnt;
    bit started;
    logic [W-1:0] n_e;
    logic [63:0] fv;
    f_done = 0; f_err = 0; f_nf = 0; started = 0; cnt = 0; hold_cnt = 0; n_e = 0;
    forever begin
      @(posedge clk); #1;
      if (!f_go) begin
        started = 0;
        if (f_done) begin
          if (hold_cnt == 0) begin f_done = 0; f_err = 0; f_nf = 0; end
          else hold_cnt--;
        end
      end else if (!started) begin
        started = 1; cnt = $urandom_range(0, 4); n_e = f_n;
      end else if (!f_done && n_e != HANG) begin
        if (cnt == 0) begin
          fv = fact64(int'(n_e));
          f_done = 1; f_err = (fv > 64'hFFFF_FFFF); f_nf = fv[W-1:0];
          hold_cnt = $urandom_range(0, 2);
        end else cnt--;
      end
    end
  end

  // Monitor: checks grants against the round-robin rule and completions against the queues.
  initial begin
    logic [N-1:0] snap;
    int last_m, own_m, g_cycle, exp_own;
    bit have_owner;
    exp_t e;
    snap = '0; last_m = N - 1; own_m = 0; g_cycle = 0; have_owner = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_m = N - 1; have_owner = 0;
        for (int i = 0; i < N; i++) q[i].delete();
      end else begin
        if (|ack) begin
          exp_own = next_owner(snap, last_m);
          chk("ack_no_done", done, 0);
          if (exp_own < 0) chk("ack_unrequested", ack, 0);
          else begin
            chk("ack_owner", ack, 64'(N'(1) << exp_own));
            chk("ack_f_go", f_go, 1);
            chk("ack_f_n", f_n, op[exp_own]);
            last_m = exp_own; own_m = exp_own; g_cycle = cycle; have_owner = 1;
          end
        end
        if (|done) begin
          if (!have_owner) chk("done_without_grant", done, 0);
          else begin
            chk("done_owner", done, 64'(N'(1) << own_m));
            if (q[own_m].size() == 0) chk("done_unexpected", done, 0);
            else begin
              e = q[own_m].pop_front();
              chk("done_res", res, e.res);
              chk("done_err", err, e.err);
              if (e.hang) chk("timeout_latency", 64'(cycle - g_cycle), TO);
            end
            have_owner = 0;
          end
        end
      end
      snap = req;
    end
  end

  task automatic requester(input int k, input int njobs, input bit hold, input bit rnd);
    logic [63:0] fv;
    int n, w;
    exp_t e;
    for (int j = 0; j < njobs; j++) begin
      if (rnd) n = ($urandom_range(0, 9) == 0) ? HANG : int'($urandom_range(0, 14));
      else n = fixed_tbl[k];
      if (n == HANG) begin e.res = 0; e.err = 1; e.hang = 1; end
      else begin fv = fact64(n); e.res = fv[W-1:0]; e.err = (fv > 64'hFFFF_FFFF); e.hang = 0; end
      op[k] = W'(n); req_n[k*W +: W] = W'(n); q[k].push_back(e); req[k] = 1;
      w = 0;
      do begin @(negedge clk); w++; end while (!ack[k] && w < 3000);
      if (!ack[k]) begin chk("ack_wait", ack[k], 1); req[k] = 0; break; end
      @(posedge clk); #1;
      if (!hold || j == njobs - 1) begin
        req[k] = 0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    active--;
  endtask

  task automatic phase(input logic [N-1:0] mask, input int njobs, input bit hold, input bit rnd);
    int w;
    for (int i = 0; i < N; i++) if (mask[i]) begin
      automatic int k = i;
      active++;
      fork requester(k, njobs, hold, rnd); join_none
    end
    wait (active == 0);
    w = 0;
    while (busy && w < 200) begin @(negedge clk); w++; end
    chk("idle_after_phase", busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);   chk({tag, "_done"}, done, 0);
    chk({tag, "_res"}, res, 0);   chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0); chk({tag, "_f_go"}, f_go, 0);
    chk({tag, "_f_n"}, f_n, 0);
  endtask

  initial begin
    int w;
    exp_t e;
    rst = 0; req = '0; req_n = '0;
    for (int i = 0; i < N; i++) op[i] = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1;

    fixed_tbl = '{5, 0, 0, 0};   phase(4'b0001, 1, 0, 0);
    fixed_tbl = '{3, 4, 0, 0};   phase(4'b0011, 2, 1, 0);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    fixed_tbl = '{1, 2, 3, 4};   phase(4'b1111, 2, 1, 0);
    fixed_tbl = '{0, HANG, 6, 0}; phase(4'b0110, 1, 0, 0);
    fixed_tbl = '{13, 0, 0, 0};  phase(4'b0001, 1, 0, 0);
    fixed_tbl = '{2, 0, 0, 0};   phase(4'b0001, 1, 0, 0);
    phase(4'b1111, 6, 0, 1);
    phase(4'b1111, 6, 1, 1);

    // Reset in the middle of a hung operation, then re-arbitrate a held request.
    op[0] = HANG; req_n[0 +: W] = HANG; req[0] = 1;
    w = 0;
    do begin @(negedge clk); w++; end while (!ack[0] && w < 50);
    chk("pre_rst_ack0", ack[0], 1);
    @(posedge clk); #1;
    req[0] = 0; op[2] = 3; req_n[2*W +: W] = 3; req[2] = 1;
    repeat (3) @(posedge clk);
    #3 rst = 0;
    #1 chk_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1;
    e.res = 6; e.err = 0; e.hang = 0; q[2].push_back(e);
    w = 0;
    do begin @(negedge clk); w++; end while (!ack[2] && w < 50);
    chk("rearb_ack2", ack[2], 1);
    @(posedge clk); #1 req[2] = 0;
    w = 0;
    do begin @(negedge clk); w++; end while (!done[2] && w < 100);
    chk("rearb_done2", done[2], 1);
    repeat (4) @(negedge clk);
    chk("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end
endmodule
